// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types, oversampling constants and divider helper
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO, power-of-2 depth
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
      $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_cnt;
   logic [AW:0]      rd_cnt;
   logic             do_push;
   logic             do_pop;

   assign level   = wr_cnt - rd_cnt;
   assign empty   = (level == '0);
   // Counters carry one extra bit, so the MSB of the difference is set only at DEPTH.
   assign full    = level[AW];
   assign head    = mem[rd_cnt[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_cnt[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (do_push) begin
            wr_cnt <= wr_cnt + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_cnt <= rd_cnt + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled 8N1 UART receiver feeding a byte FIFO
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 14745600,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          RX,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          clr_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int CW  = $clog2(DIV);

   if (DIV < 2 || (CLK_FREQ % (BAUD * OVERSAMPLE)) != 0) begin : g_div_check
      $error("uart_rx_fifo: CLK_FREQ/(BAUD*16) must be an integer of at least 2");
   end

   logic           rx_meta;
   logic           rx_s;
   logic [CW-1:0]  div_cnt;
   logic           tick;
   logic           start_det;
   uart_rx_state_t state;
   logic [3:0]     sc;
   logic [2:0]     bi;
   logic [7:0]     shift;
   logic           push;
   logic           full;
   logic           empty;
   logic           drop;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   assign tick      = (div_cnt == CW'(DIV - 1));
   assign start_det = (state == IDLE) && !rx_s;

   // Reloading on the start edge puts every later tick at a fixed phase to the frame.
   always_ff @(posedge Clk) begin
      if (Rst || start_det || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         sc        <= '0;
         bi        <= '0;
         shift     <= '0;
         push      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         push <= 1'b0;
         if (clr_err) begin
            frame_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  sc    <= '0;
               end
            end
            START: begin
               if (tick) begin
                  sc <= sc + 4'd1;
                  if (sc == 4'(MID_SAMPLE)) begin
                     if (!rx_s) begin
                        state <= DATA;
                        sc    <= '0;
                        bi    <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  sc <= sc + 4'd1;
                  if (sc == 4'(OVERSAMPLE - 1)) begin
                     shift <= {rx_s, shift[7:1]};
                     if (bi == 3'd7) begin
                        state <= STOP;
                        sc    <= '0;
                     end else begin
                        bi <= bi + 3'd1;
                     end
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  sc <= sc + 4'd1;
                  if (sc == 4'(OVERSAMPLE - 1)) begin
                     if (rx_s) begin
                        push  <= 1'b1;
                        state <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                     end
                  end
               end
            end
            BREAK: begin
               // A held-low line must return high before another start bit is accepted.
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign drop = push && full && !(rx_ready && !empty);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_err) begin
         overrun <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (Clk),
      .rst       (Rst),
      .push      (push),
      .push_data (shift),
      .pop       (rx_ready),
      .head      (rx_data),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   assign rx_valid = !empty;

endmodule
